// File: rtl/ex_stage_pkg.sv
// Shared widths, MIPS funct codes and divider state type for the execute stage.
package ex_stage_pkg;

  localparam int unsigned DATA_BUS_WIDTH     = 32;
  localparam int unsigned REG_ADDR_BUS_WIDTH = 5;
  localparam int unsigned HI_LO_WIDTH        = 2 * DATA_BUS_WIDTH;
  localparam int unsigned FUNCT_WIDTH        = 6;
  localparam int unsigned SHAMT_WIDTH        = 5;
  localparam int unsigned MEM_SEL_WIDTH      = 4;

  typedef logic [DATA_BUS_WIDTH-1:0] data_t;

  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL   = 6'h00;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL   = 6'h02;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRA   = 6'h03;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLLV  = 6'h04;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRLV  = 6'h06;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRAV  = 6'h07;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD   = 6'h20;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADDU  = 6'h21;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUB   = 6'h22;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUBU  = 6'h23;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND   = 6'h24;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR    = 6'h25;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_XOR   = 6'h26;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_NOR   = 6'h27;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLT   = 6'h2A;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLTU  = 6'h2B;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  // Absolute value when the operand is treated as signed, otherwise unchanged.
  function automatic data_t magnitude(input data_t v, input logic signed_op);
    return (signed_op && v[DATA_BUS_WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM-facing outputs of the execute stage.
interface ex_stage_if
  import ex_stage_pkg::*;
;
  logic                          stall_current_stage;
  logic [FUNCT_WIDTH-1:0]        funct;
  logic [SHAMT_WIDTH-1:0]        shamt;
  data_t                         operand_1;
  data_t                         operand_2;
  logic                          mem_read_flag_in;
  logic                          mem_write_flag_in;
  logic                          mem_sign_ext_flag_in;
  logic [MEM_SEL_WIDTH-1:0]      mem_sel_in;
  data_t                         mem_write_data_in;
  logic                          write_reg_en_in;
  logic [REG_ADDR_BUS_WIDTH-1:0] write_reg_addr_in;
  data_t                         debug_pc_addr_in;

  data_t                         result;
  logic                          stall_request;
  logic                          mem_read_flag_out;
  logic                          mem_write_flag_out;
  logic                          mem_sign_ext_flag_out;
  logic [MEM_SEL_WIDTH-1:0]      mem_sel_out;
  data_t                         mem_write_data_out;
  logic                          write_reg_en_out;
  logic [REG_ADDR_BUS_WIDTH-1:0] write_reg_addr_out;
  data_t                         debug_pc_addr_out;

  modport master (
    output stall_current_stage, funct, shamt, operand_1, operand_2,
           mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in, mem_sel_in,
           mem_write_data_in, write_reg_en_in, write_reg_addr_in, debug_pc_addr_in,
    input  result, stall_request, mem_read_flag_out, mem_write_flag_out,
           mem_sign_ext_flag_out, mem_sel_out, mem_write_data_out, write_reg_en_out,
           write_reg_addr_out, debug_pc_addr_out
  );

  modport slave (
    input  stall_current_stage, funct, shamt, operand_1, operand_2,
           mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in, mem_sel_in,
           mem_write_data_in, write_reg_en_in, write_reg_addr_in, debug_pc_addr_in,
    output result, stall_request, mem_read_flag_out, mem_write_flag_out,
           mem_sign_ext_flag_out, mem_sel_out, mem_write_data_out, write_reg_en_out,
           write_reg_addr_out, debug_pc_addr_out
  );

endinterface

// File: rtl/ex_stage_divider.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, sign fix-up on output.
module ex_stage_divider
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DATA_BUS_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  logic  signed_op,
  input  data_t dividend,
  input  data_t divisor,
  input  logic  ack,
  output logic  busy,
  output logic  done,
  output data_t quotient,
  output data_t remainder
);

  localparam int unsigned W     = DATA_BUS_WIDTH;
  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  div_state_e       state;
  logic [CNT_W-1:0] count;
  data_t            quo_q;
  data_t            rem_q;
  data_t            den_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [W:0]       partial;

  // Remainder shifted left with the next dividend bit brought down.
  assign partial = {rem_q, quo_q[W-1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= DIV_IDLE;
      count     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      den_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            quo_q     <= magnitude(dividend, signed_op);
            den_q     <= magnitude(divisor, signed_op);
            rem_q     <= '0;
            neg_quo_q <= signed_op & (dividend[W-1] ^ divisor[W-1]);
            neg_rem_q <= signed_op & dividend[W-1];
            count     <= '0;
            state     <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (partial >= {1'b0, den_q}) begin
            rem_q <= W'(partial - {1'b0, den_q});
            quo_q <= {quo_q[W-2:0], 1'b1};
          end else begin
            rem_q <= partial[W-1:0];
            quo_q <= {quo_q[W-2:0], 1'b0};
          end
          count <= count + CNT_W'(1);
          if (count == CNT_W'(DIV_CYCLES - 1)) state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (ack) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  // Stall is raised in the issuing cycle itself, before the state leaves IDLE.
  assign busy      = (state == DIV_BUSY) || ((state == DIV_IDLE) && start);
  assign done      = (state == DIV_DONE);
  assign quotient  = neg_quo_q ? -quo_q : quo_q;
  assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU, HI/LO with multiply, and iterative divide with stall.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DATA_BUS_WIDTH
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave ex
);

  data_t                   hi;
  data_t                   lo;
  logic                    div_start;
  logic                    div_done;
  data_t                   div_quotient;
  data_t                   div_remainder;
  logic [HI_LO_WIDTH-1:0]  prod_u;
  logic signed [HI_LO_WIDTH-1:0] prod_s;

  assign div_start = (ex.funct == FUNCT_DIV) || (ex.funct == FUNCT_DIVU);

  ex_stage_divider #(.DIV_CYCLES(DIV_CYCLES)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (ex.funct == FUNCT_DIV),
    .dividend  (ex.operand_1),
    .divisor   (ex.operand_2),
    .ack       (!ex.stall_current_stage),
    .busy      (ex.stall_request),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  assign prod_s = HI_LO_WIDTH'($signed(ex.operand_1)) * HI_LO_WIDTH'($signed(ex.operand_2));
  assign prod_u = HI_LO_WIDTH'(ex.operand_1) * HI_LO_WIDTH'(ex.operand_2);

  // HI/LO commit; a finished divide owns the write port while it waits in DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!ex.stall_current_stage) begin
      if (div_done) begin
        hi <= div_remainder;
        lo <= div_quotient;
      end else begin
        case (ex.funct)
          FUNCT_MTHI:  hi <= ex.operand_1;
          FUNCT_MTLO:  lo <= ex.operand_1;
          FUNCT_MULT:  {hi, lo} <= prod_s;
          FUNCT_MULTU: {hi, lo} <= prod_u;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ex.result = '0;
    case (ex.funct)
      FUNCT_ADD, FUNCT_ADDU: ex.result = ex.operand_1 + ex.operand_2;
      FUNCT_SUB, FUNCT_SUBU: ex.result = ex.operand_1 - ex.operand_2;
      FUNCT_AND:  ex.result = ex.operand_1 & ex.operand_2;
      FUNCT_OR:   ex.result = ex.operand_1 | ex.operand_2;
      FUNCT_XOR:  ex.result = ex.operand_1 ^ ex.operand_2;
      FUNCT_NOR:  ex.result = ~(ex.operand_1 | ex.operand_2);
      FUNCT_SLT:  ex.result = DATA_BUS_WIDTH'($signed(ex.operand_1) < $signed(ex.operand_2));
      FUNCT_SLTU: ex.result = DATA_BUS_WIDTH'(ex.operand_1 < ex.operand_2);
      FUNCT_SLL:  ex.result = ex.operand_2 << ex.shamt;
      FUNCT_SRL:  ex.result = ex.operand_2 >> ex.shamt;
      FUNCT_SRA:  ex.result = $signed(ex.operand_2) >>> ex.shamt;
      FUNCT_SLLV: ex.result = ex.operand_2 << ex.operand_1[4:0];
      FUNCT_SRLV: ex.result = ex.operand_2 >> ex.operand_1[4:0];
      FUNCT_SRAV: ex.result = $signed(ex.operand_2) >>> ex.operand_1[4:0];
      FUNCT_MFHI: ex.result = hi;
      FUNCT_MFLO: ex.result = lo;
      default: ;
    endcase
  end

  assign ex.mem_read_flag_out     = ex.mem_read_flag_in;
  assign ex.mem_write_flag_out    = ex.mem_write_flag_in;
  assign ex.mem_sign_ext_flag_out = ex.mem_sign_ext_flag_in;
  assign ex.mem_sel_out           = ex.mem_sel_in;
  assign ex.mem_write_data_out    = ex.mem_write_data_in;
  assign ex.write_reg_en_out      = ex.write_reg_en_in;
  assign ex.write_reg_addr_out    = ex.write_reg_addr_in;
  assign ex.debug_pc_addr_out     = ex.debug_pc_addr_in;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table, hand-written divide sequences, random ops vs a reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  ex_stage_if bus ();

  ex_stage dut (.clk(clk), .rst(rst), .ex(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [13];
  logic [5:0]  ops [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sra_ref(input logic [31:0] v, input logic [4:0] s);
    logic [31:0] fill;
    fill = v[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0;
    return (v >> s) | fill;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [5:0] f, input logic [4:0] sh,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
    case (f)
      FUNCT_ADD, FUNCT_ADDU: return a + b;
      FUNCT_SUB, FUNCT_SUBU: return a - b;
      FUNCT_AND:  return a & b;
      FUNCT_OR:   return a | b;
      FUNCT_XOR:  return a ^ b;
      FUNCT_NOR:  return ~(a | b);
      FUNCT_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      FUNCT_SLTU: return (a < b) ? 32'd1 : 32'd0;
      FUNCT_SLL:  return b << sh;
      FUNCT_SRL:  return b >> sh;
      FUNCT_SRA:  return sra_ref(b, sh);
      FUNCT_SLLV: return b << a[4:0];
      FUNCT_SRLV: return b >> a[4:0];
      FUNCT_SRAV: return sra_ref(b, a[4:0]);
      FUNCT_MFHI: return hi;
      FUNCT_MFLO: return lo;
      default:    return 32'd0;
    endcase
  endfunction

  // Returns {remainder, quotient} from plain integer arithmetic on magnitudes.
  function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ma, mb, q, r;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q  = (mb == 0) ? longint'(32'hFFFF_FFFF) : ma / mb;
    r  = (mb == 0) ? ma : ma % mb;
    if ((sa < 0) != (sb < 0)) q = -q;
    if (sa < 0) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic clear_inputs();
    bus.stall_current_stage  = 1'b0;
    bus.funct                = 6'd0;
    bus.shamt                = 5'd0;
    bus.operand_1            = 32'd0;
    bus.operand_2            = 32'd0;
    bus.mem_read_flag_in     = 1'b0;
    bus.mem_write_flag_in    = 1'b0;
    bus.mem_sign_ext_flag_in = 1'b0;
    bus.mem_sel_in           = 4'd0;
    bus.mem_write_data_in    = 32'd0;
    bus.write_reg_en_in      = 1'b0;
    bus.write_reg_addr_in    = 5'd0;
    bus.debug_pc_addr_in     = 32'd0;
  endtask

  task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.funct = FUNCT_MFHI;
    @(negedge clk);
    check({name, "_hi"}, bus.result, exp_hi);
    @(posedge clk); #1;
    bus.funct = FUNCT_MFLO;
    @(negedge clk);
    check({name, "_lo"}, bus.result, exp_lo);
    @(posedge clk); #1;
  endtask

  // Issue a divide, count stall cycles (scrambling operands while busy), let it commit.
  task automatic run_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int n;
    bus.funct = f; bus.operand_1 = a; bus.operand_2 = b;
    bus.stall_current_stage = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.stall_request) break;
      n++;
      @(posedge clk); #1;
      bus.operand_1 = $urandom;
      bus.operand_2 = $urandom;
    end
    check("div_stall_cycles", 32'(n), 32'd33);
    @(posedge clk); #1;
    r = div_ref(f == FUNCT_DIV, a, b);
    m_hi = r[63:32];
    m_lo = r[31:0];
  endtask

  task automatic hold_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] r;
    int n;
    bus.funct = f; bus.operand_1 = a; bus.operand_2 = b;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.stall_request) break;
      n++;
      @(posedge clk); #1;
    end
    check("hold_stall_cycles", 32'(n), 32'd33);
    for (int i = 0; i < hold; i++) begin
      bus.stall_current_stage = 1'b1;
      bus.funct = FUNCT_MFHI;
      #1;
      check("hold_hi_unchanged", bus.result, m_hi);
      check("hold_stall_low", 32'(bus.stall_request), 32'd0);
      bus.funct = FUNCT_MFLO;
      #1;
      check("hold_lo_unchanged", bus.result, m_lo);
      @(posedge clk); #1;
    end
    bus.stall_current_stage = 1'b0;
    bus.funct = f;
    @(posedge clk); #1;
    r = div_ref(f == FUNCT_DIV, a, b);
    m_hi = r[63:32];
    m_lo = r[31:0];
  endtask

  initial begin
    logic [5:0]  f;
    logic [4:0]  sh;
    logic [31:0] a, b;
    logic        stl;
    logic [12:0] side;
    logic [63:0] p;

    vecs[0]  = '{FUNCT_ADDU, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{FUNCT_SRAV, 5'd0, 32'h0000_0004, 32'hF000_0000, 32'hFF00_0000};
    vecs[2]  = '{FUNCT_SLT,  5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[3]  = '{FUNCT_SLTU, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[4]  = '{FUNCT_SUB,  5'd0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vecs[5]  = '{FUNCT_NOR,  5'd0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F};
    vecs[6]  = '{FUNCT_SLL,  5'd4, 32'h1234_5678, 32'h0000_00FF, 32'h0000_0FF0};
    vecs[7]  = '{FUNCT_SRL,  5'd8, 32'h0000_0000, 32'h8000_0000, 32'h0080_0000};
    vecs[8]  = '{FUNCT_SRA,  5'd8, 32'h0000_0000, 32'h8000_0000, 32'hFF80_0000};
    vecs[9]  = '{FUNCT_SRLV, 5'd0, 32'h0000_0023, 32'h0000_0080, 32'h0000_0010};
    vecs[10] = '{FUNCT_XOR,  5'd0, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
    vecs[11] = '{6'h3F,      5'd0, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000};
    vecs[12] = '{FUNCT_ADD,  5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};

    ops = '{FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV,
            FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO, FUNCT_MULT, FUNCT_MULTU,
            FUNCT_ADD, FUNCT_SUBU, FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
            FUNCT_SLT, FUNCT_SLTU};

    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_stall", 32'(bus.stall_request), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_passthru", bus.debug_pc_addr_out, 32'd0);
    @(posedge clk); #1;
    read_hilo("reset_hilo", 32'd0, 32'd0);

    for (int i = 0; i < 13; i++) begin
      bus.funct = vecs[i].funct; bus.shamt = vecs[i].shamt;
      bus.operand_1 = vecs[i].a; bus.operand_2 = vecs[i].b;
      @(negedge clk);
      check($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
      check($sformatf("vec%0d_stall", i), 32'(bus.stall_request), 32'd0);
      @(posedge clk); #1;
    end

    bus.funct = FUNCT_MULT; bus.operand_1 = 32'hFFFF_FFFE; bus.operand_2 = 32'd3;
    @(negedge clk);
    check("mult_stall", 32'(bus.stall_request), 32'd0);
    @(posedge clk); #1;
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFA;
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    bus.funct = FUNCT_MULTU; bus.operand_1 = 32'hFFFF_FFFF; bus.operand_2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    read_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    run_div(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    read_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div(FUNCT_DIVU, 32'd100, 32'd7);
    read_hilo("divu_100_7", 32'd2, 32'd14);
    run_div(FUNCT_DIVU, 32'd5, 32'd0);
    read_hilo("divu_5_0", 32'd5, 32'hFFFF_FFFF);
    run_div(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    read_hilo("div_min_m1", 32'd0, 32'h8000_0000);

    hold_div(FUNCT_DIV, 32'd100, 32'hFFFF_FFF9, 3);
    read_hilo("div_held", 32'd2, 32'hFFFF_FFF2);
    read_hilo("div_held_again", 32'd2, 32'hFFFF_FFF2);

    bus.funct = FUNCT_DIVU; bus.operand_1 = 32'd1000; bus.operand_2 = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    check("mid_div_stall_high", 32'(bus.stall_request), 32'd1);
    rst = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    check("rst_mid_div_stall", 32'(bus.stall_request), 32'd0);
    @(posedge clk); #1;
    read_hilo("rst_mid_div", 32'd0, 32'd0);
    run_div(FUNCT_DIVU, 32'd9, 32'd3);
    read_hilo("divu_9_3", 32'd0, 32'd3);

    for (int it = 0; it < 150; it++) begin
      int unsigned pick;
      pick = $urandom_range(0, 19);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
      if ($urandom_range(0, 2) == 0) a = 32'($signed(32'($urandom_range(0, 200))) - 100);
      if (pick == 0 || pick == 1) begin
        run_div(pick == 0 ? FUNCT_DIV : FUNCT_DIVU, a, b);
        continue;
      end
      f  = (pick == 2) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 19)];
      if (f == FUNCT_DIV || f == FUNCT_DIVU) f = FUNCT_ADDU;
      sh  = 5'($urandom);
      stl = ($urandom_range(0, 3) == 0);
      side = 13'($urandom);
      bus.funct = f; bus.shamt = sh; bus.operand_1 = a; bus.operand_2 = b;
      bus.stall_current_stage = stl;
      {bus.mem_read_flag_in, bus.mem_write_flag_in, bus.mem_sign_ext_flag_in,
       bus.mem_sel_in, bus.write_reg_en_in, bus.write_reg_addr_in} = side;
      bus.mem_write_data_in = $urandom;
      bus.debug_pc_addr_in  = $urandom;
      @(negedge clk);
      check("rand_result", bus.result, alu_ref(f, sh, a, b, m_hi, m_lo));
      check("rand_stall", 32'(bus.stall_request), 32'd0);
      check("rand_side", 32'({bus.mem_read_flag_out, bus.mem_write_flag_out, bus.mem_sign_ext_flag_out,
                              bus.mem_sel_out, bus.write_reg_en_out, bus.write_reg_addr_out}), 32'(side));
      check("rand_wdata", bus.mem_write_data_out, bus.mem_write_data_in);
      check("rand_pc", bus.debug_pc_addr_out, bus.debug_pc_addr_in);
      @(posedge clk); #1;
      if (!stl) begin
        case (f)
          FUNCT_MTHI: m_hi = a;
          FUNCT_MTLO: m_lo = a;
          FUNCT_MULT: begin
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            {m_hi, m_lo} = p;
          end
          FUNCT_MULTU: begin
            p = 64'(a) * 64'(b);
            {m_hi, m_lo} = p;
          end
          default: ;
        endcase
      end
      bus.stall_current_stage = 1'b0;
    end
    read_hilo("final_hilo", m_hi, m_lo);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX pipeline register outputs and computes the ALU/shift result.
- Owns the HI/LO registers and the multiply/divide unit.
- Raises a stall request while an iterative divide is in progress.
- Result and pass-through memory/writeback controls feed the EX/MEM pipeline register combinationally.

Parameters:
- DIV_CYCLES, 32, number of divider iterations (one quotient bit per cycle). Must equal DATA_BUS_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- stall_current_stage  in  1  EX held by the downstream stall; blocks HI/LO commit
- funct  in  6  ALU operation (MIPS funct encoding)
- shamt  in  5  immediate shift amount
- operand_1  in  32  rs value
- operand_2  in  32  rt value or extended immediate
- mem_read_flag_in / mem_write_flag_in / mem_sign_ext_flag_in  in  1 each  pass-through
- mem_sel_in  in  4  pass-through
- mem_write_data_in  in  32  pass-through
- write_reg_en_in  in  1  pass-through
- write_reg_addr_in  in  5  pass-through
- debug_pc_addr_in  in  32  pass-through
- result  out  32  ALU / MFHI / MFLO result
- stall_request  out  1  asks the pipeline controller to freeze IF..EX
- mem_*_out, write_reg_en_out, write_reg_addr_out, debug_pc_addr_out  out  as inputs  combinational copies of the inputs

Behaviour:
- Datapath:
  - ALU path is combinational, result valid in the same cycle.
  - ADD/ADDU and SUB/SUBU are identical (mod 2^32); no overflow exception in this block.
  - AND/OR/XOR/NOR bitwise.
  - SLT signed compare, SLTU unsigned compare; result 0 or 1.
  - SLL/SRL/SRA use shamt. SLLV/SRLV/SRAV use operand_1[4:0] as the amount and shift operand_2.
  - Unknown funct -> result 0.
- HI/LO registers:
  - Reset to 0. Write only on the rising edge, and only when stall_current_stage=0 and the instruction completes this cycle.
  - MTHI writes HI=operand_1; MTLO writes LO=operand_1.
  - MFHI/MFLO return the registered value. An instruction immediately following a writer sees the new value; no internal forwarding is required.
- Multiply:
  - MULT (signed) / MULTU: 64-bit product computed combinationally.
  - {HI,LO} written at the end of the EX cycle; single cycle, no stall.
- Divide FSM, states IDLE, BUSY, DONE:
  - IDLE & funct∈{DIV,DIVU}: stall_request=1 combinationally. On the edge, latch |dividend|, |divisor|, sign flags and signedness; counter=0 -> BUSY.
  - BUSY: restoring step each cycle; stall_request=1. Counter increments; at counter==DIV_CYCLES-1 -> DONE.
  - DONE: stall_request=0. If stall_current_stage=0, commit HI=remainder, LO=quotient -> IDLE. Otherwise hold in DONE with no commit.
  - Timing: a DIV entering EX at cycle N holds stall_request high for cycles N..N+32 and commits at the end of N+33.
- Divide sign and width rules:
  - Quotient is negative iff operand signs differ (signed only). Remainder takes the dividend's sign.
  - 0x80000000 / -1 signed -> LO=0x80000000, HI=0.
- Divide by zero:
  - No trap, fixed result: unsigned magnitude quotient = 0xFFFFFFFF and remainder = dividend, then sign fix-up applied.
- Reset and robustness:
  - Reset at any time, including mid-divide: FSM->IDLE, counter=0, HI=LO=0, stall_request=0 in the following cycle.
  - Operand changes while BUSY are ignored; the latched copies are used.
- Reset values of outputs:
  - stall_request=0.
  - result and pass-throughs follow the inputs combinationally (0 when the ID/EX register is reset).

Decomposition:
- Shared header (alongside bus.v): funct codes (FUNCT_ADD, FUNCT_DIV, ...), DATA_BUS/REG_ADDR_BUS widths, HI/LO width macros.
- One sub-module, divider: start, signed_op, dividend, divisor -> busy, done, quotient, remainder. Contains the FSM and iteration counter.
- ALU, multiply and HI/LO stay in ex_stage.

Test Plan:
- ADDU 0x7FFFFFFF+1 -> result 0x80000000, stall_request 0. SRAV operand_1=4, operand_2=0xF0000000 -> 0xFF000000. SLT -1,1 -> 1; SLTU same operands -> 0.
- MULT 0xFFFFFFFE × 3, then MFHI, MFLO -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; no stall cycles.
- DIV -7 / 2 -> stall_request high exactly 33 cycles; then MFLO=0xFFFFFFFD, MFHI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. Signed 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIV completing while stall_current_stage=1 for 3 cycles -> HI/LO unchanged until the stall drops, then committed once.
- rst=0 asserted at BUSY cycle 10 -> next cycle stall_request=0, HI=LO=0. A new DIVU 9/3 afterwards -> LO=3, HI=0.
